// File: rtl/beat_pkg.sv
// Shared mode encodings for the beat recorder: controller, buzzer mixer
// and display decoder all agree on these values.
package beat_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_REC  = 2'b01;
    localparam logic [1:0] MODE_DUB  = 2'b10;
    localparam logic [1:0] MODE_PLAY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = MODE_IDLE,
        ST_REC  = MODE_REC,
        ST_DUB  = MODE_DUB,
        ST_PLAY = MODE_PLAY
    } beat_state_e;

endpackage

// File: rtl/beat_addr_counter.sv
// Track address counter: wraps at a runtime limit for playback,
// saturates at DEPTH for recording, and flags the wrap step.
module beat_addr_counter #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic            i_wrap,
    input  logic [ADDR_W:0] i_limit,
    output logic [ADDR_W:0] o_cnt,
    output logic            o_wrap
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] r_cnt;
    logic            w_at_lim;

    assign w_at_lim = (r_cnt == i_limit - 1'b1);
    assign o_wrap   = i_en & i_wrap & w_at_lim;
    assign o_cnt    = r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_wrap)
                r_cnt <= w_at_lim ? '0 : r_cnt + 1'b1;
            else if (r_cnt != DEPTH)
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/beat_track_ctrl.sv
// Mode controller for the multi-track beat recorder: owns the RAM
// address/strobe, per-track lengths and the live/memory source selects.
module beat_track_ctrl
    import beat_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int N_TRACKS = 4,
    localparam int TRK_W   = $clog2(N_TRACKS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sw_record,
    input  logic              sw_play,
    input  logic              sw_overdub,
    input  logic [TRK_W-1:0]  track_sel,
    input  logic              tick,
    output logic [1:0]        mode,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [TRK_W-1:0]  ram_track,
    output logic              kb_record,
    output logic              mem_play,
    output logic              loop_pulse,
    output logic              rec_full
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    beat_state_e      r_state;
    beat_state_e      w_nxt;
    logic [TRK_W-1:0] r_trk;
    logic [ADDR_W:0]  r_len [N_TRACKS];
    logic             r_pend;

    logic [ADDR_W:0]  w_cnt;
    logic [ADDR_W:0]  w_cur_len;
    logic             w_clr;
    logic             w_stay;
    logic             w_adv;
    logic             w_wrap;
    logic             w_wrap_mode;
    logic             w_is_rec;

    assign w_cur_len   = r_len[r_trk];
    assign w_is_rec    = (r_state == ST_REC);
    assign w_wrap_mode = !w_is_rec;
    assign mode        = r_state;
    assign ram_track   = r_trk;

    always_comb begin
        w_nxt  = r_state;
        w_clr  = 1'b0;
        w_stay = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = sw_record | sw_play | sw_overdub;
                if (sw_record)
                    w_nxt = ST_REC;
                else if (sw_play)
                    w_nxt = ST_PLAY;
                else if (sw_overdub)
                    w_nxt = ST_DUB;
            end
            ST_REC:  w_stay = sw_record;
            ST_PLAY: w_stay = sw_play;
            ST_DUB:  w_stay = sw_overdub;
            default: w_stay = 1'b0;
        endcase
        if (r_state != ST_IDLE && !w_stay)
            w_nxt = ST_IDLE;
    end

    // A dropping switch beats a coincident tick, so advance needs w_stay.
    assign w_adv = tick & w_stay &
                   (w_is_rec ? (w_cnt != DEPTH) : (w_cur_len != '0));

    beat_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_clr   (w_clr),
        .i_en    (w_adv),
        .i_wrap  (w_wrap_mode),
        .i_limit (w_cur_len),
        .o_cnt   (w_cnt),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_trk      <= '0;
            r_pend     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            kb_record  <= 1'b0;
            mem_play   <= 1'b0;
            loop_pulse <= 1'b0;
            rec_full   <= 1'b0;
            for (int i = 0; i < N_TRACKS; i++)
                r_len[i] <= '0;
        end else begin
            r_state    <= w_nxt;
            kb_record  <= (w_nxt == ST_REC) || (w_nxt == ST_DUB);
            mem_play   <= (w_nxt == ST_PLAY) || (w_nxt == ST_DUB);
            ram_we     <= w_adv && (r_state != ST_PLAY);
            loop_pulse <= w_adv && w_wrap_mode && r_pend;
            if (w_adv)
                ram_addr <= w_cnt[ADDR_W-1:0];
            // The wrap is remembered and reported on the next tick, at address 0.
            if (w_clr) begin
                r_trk  <= track_sel;
                r_pend <= 1'b0;
            end else if (w_adv && w_wrap_mode) begin
                r_pend <= w_wrap;
            end
            if (w_is_rec && !w_stay) begin
                r_len[r_trk] <= w_cnt;
                rec_full     <= 1'b0;
            end else if (w_adv && w_is_rec && w_cnt == DEPTH - 1'b1) begin
                rec_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_beat_track_ctrl.sv
// Bench for beat_track_ctrl: directed scenarios plus random switch/tick
// traffic, all outputs compared against a behavioural track model.
module tb_beat_track_ctrl;

    localparam int AW    = 3;
    localparam int NT    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sw_record = 1'b0;
    logic          sw_play = 1'b0;
    logic          sw_overdub = 1'b0;
    logic [TW-1:0] track_sel = '0;
    logic          tick = 1'b0;
    logic [1:0]    mode;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [TW-1:0] ram_track;
    logic          kb_record;
    logic          mem_play;
    logic          loop_pulse;
    logic          rec_full;

    beat_track_ctrl #(
        .ADDR_W   (AW),
        .N_TRACKS (NT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sw_record  (sw_record),
        .sw_play    (sw_play),
        .sw_overdub (sw_overdub),
        .track_sel  (track_sel),
        .tick       (tick),
        .mode       (mode),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_track  (ram_track),
        .kb_record  (kb_record),
        .mem_play   (mem_play),
        .loop_pulse (loop_pulse),
        .rec_full   (rec_full)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: mode 0 idle, 1 rec, 2 dub, 3 play
    int m_mode, m_trk, m_pos, m_pend;
    int m_len [NT];
    int e_we, e_addr, e_lp, e_full;

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_trk = 0; m_pos = 0; m_pend = 0;
        for (int i = 0; i < NT; i++) m_len[i] = 0;
        e_we = 0; e_addr = 0; e_lp = 0; e_full = 0;
    endtask

    task automatic m_edge(input bit r, input bit p, input bit d,
                          input int sel, input bit t);
        bit own;
        e_we = 0;
        e_lp = 0;
        if (m_mode == 0) begin
            if (r || p || d) begin
                m_mode = r ? 1 : (p ? 3 : 2);
                m_trk  = sel;
                m_pos  = 0;
                m_pend = 0;
            end
        end else begin
            own = (m_mode == 1) ? r : ((m_mode == 3) ? p : d);
            if (!own) begin
                if (m_mode == 1) m_len[m_trk] = m_pos;
                m_mode = 0;
                e_full = 0;
            end else if (t) begin
                if (m_mode == 1) begin
                    if (m_pos < DEPTH) begin
                        e_we = 1; e_addr = m_pos; m_pos++;
                        e_full = (m_pos == DEPTH);
                    end
                end else if (m_len[m_trk] != 0) begin
                    e_we   = (m_mode == 2);
                    e_addr = m_pos;
                    e_lp   = m_pend;
                    m_pos  = (m_pos + 1) % m_len[m_trk];
                    m_pend = (m_pos == 0);
                end
            end
        end
    endtask

    task automatic check_all();
        chk_eq("mode", mode, m_mode);
        chk_eq("ram_we", ram_we, e_we);
        chk_eq("ram_addr", ram_addr, e_addr);
        chk_eq("ram_track", ram_track, m_trk);
        chk_eq("kb_record", kb_record, (m_mode == 1 || m_mode == 2));
        chk_eq("mem_play", mem_play, (m_mode == 2 || m_mode == 3));
        chk_eq("loop_pulse", loop_pulse, e_lp);
        chk_eq("rec_full", rec_full, e_full);
    endtask

    task automatic cyc(input bit r, input bit p, input bit d,
                       input int sel, input bit t);
        sw_record  = r;
        sw_play    = p;
        sw_overdub = d;
        track_sel  = TW'(sel);
        tick       = t;
        m_edge(r, p, d, sel, t);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input bit r, input bit p, input bit d,
                        input int sel, input int nt);
        for (int i = 0; i < nt; i++) begin
            cyc(r, p, d, sel, 1'b0);
            cyc(r, p, d, sel, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        sw_record = 0; sw_play = 0; sw_overdub = 0; tick = 0;
        resetn = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        bit [2:0] sw;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        resetn = 1'b1;

        hold(1, 0, 0, 0, 5);
        do_reset();
        hold(0, 1, 0, 0, 4);
        idle(2);

        hold(1, 0, 0, 2, 3);
        idle(1);
        hold(0, 1, 0, 2, 8);
        idle(1);

        hold(1, 0, 0, 3, 10);
        idle(1);
        hold(0, 1, 0, 3, 10);
        idle(1);

        hold(1, 1, 0, 1, 2);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        hold(0, 1, 0, 1, 3);
        idle(1);

        hold(1, 0, 0, 0, 4);
        idle(1);
        hold(0, 0, 1, 0, 5);
        idle(1);
        hold(0, 1, 0, 1, 3);
        hold(0, 1, 0, 0, 5);
        idle(1);

        hold(1, 0, 0, 2, 2);
        cyc(0, 0, 0, 2, 1);
        idle(1);
        hold(0, 1, 0, 2, 4);
        idle(1);

        sw = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) sw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 799) == 0) do_reset();
            cyc(sw[2], sw[1], sw[0], int'($urandom_range(0, NT - 1)),
                1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
